ff_en_arbiter: RTL and testbench

FF_EN_ARBITER -- requirements
Module: ff_en_arbiter

---
 rtl/ff_en_arbiter.sv | 138 +++++++++++++
 tb/tb_ff_en_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ff_en_arbiter.sv
// ff_en_arbiter
//   Shares one enabled register (ff_en) among four requesters. In round-robin
//   order it grants one write, drives the data with a one-cycle enable, reads
//   the register back one cycle later and acknowledges the requester. A
//   mismatch between the read-back and the written value is flagged and
//   counted.
//
// Ports
//   clock     : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   rdy       : the ff_en instance is usable (1) / not usable (0)
//   req       : per-requester write request, level, held until ack
//   wdata     : write data, requester i on bits [i*WIDTH +: WIDTH]
//   ack       : one-cycle completion pulse to the granted requester
//   d_in      : data to the ff_en instance (held after the write)
//   d_en      : enable to the ff_en instance
//   d_out     : registered output of the ff_en instance
//   rd_data   : d_out captured at check time
//   rd_id     : ID of the requester whose write produced rd_data
//   mismatch  : one-cycle pulse with ack when read-back differs from write
//   err_cnt   : saturating count of mismatches
module ff_en_arbiter #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned NREQ  = 4
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  wdata,
  output logic [NREQ-1:0]        ack,
  output logic [WIDTH-1:0]       d_in,
  output logic                   d_en,
  input  logic [WIDTH-1:0]       d_out,
  output logic [WIDTH-1:0]       rd_data,
  output logic [1:0]             rd_id,
  output logic                   mismatch,
  output logic [7:0]             err_cnt
);

  typedef enum logic [1:0] {
    WAIT_RDY = 2'd0,
    IDLE     = 2'd1,
    WRITE    = 2'd2,
    CHECK    = 2'd3
  } state_t;

  state_t            state_q;
  logic [1:0]        ptr_q;
  logic [1:0]        id_q;
  logic [NREQ-1:0]   ack_q;
  logic [WIDTH-1:0]  d_in_q;
  logic              d_en_q;
  logic [WIDTH-1:0]  rd_data_q;
  logic [1:0]        rd_id_q;
  logic              mismatch_q;
  logic [7:0]        err_cnt_q;

  logic              win_vld_d;
  logic [1:0]        win_id_d;
  logic [1:0]        cand;

  // Round-robin search: first set req bit at ptr, ptr+1, ... modulo 4.
  always_comb begin
    win_vld_d = 1'b0;
    win_id_d  = ptr_q;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = ptr_q + i[1:0];
      if (!win_vld_d && req[cand]) begin
        win_vld_d = 1'b1;
        win_id_d  = cand;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= WAIT_RDY;
      ptr_q      <= '0;
      id_q       <= '0;
      ack_q      <= '0;
      d_in_q     <= '0;
      d_en_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_id_q    <= '0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      // Pulses default low; each state raises them only where needed.
      ack_q      <= '0;
      mismatch_q <= 1'b0;
      d_en_q     <= 1'b0;
      if (!rdy && state_q != WAIT_RDY) begin
        // Fabric went away: abandon the transaction, req stays pending.
        state_q <= WAIT_RDY;
      end else begin
        unique case (state_q)
          WAIT_RDY: begin
            if (rdy) state_q <= IDLE;
          end
          IDLE: begin
            if (win_vld_d) begin
              id_q    <= win_id_d;
              d_in_q  <= wdata[win_id_d*WIDTH +: WIDTH];
              d_en_q  <= 1'b1;
              state_q <= WRITE;
            end
          end
          WRITE: begin
            state_q <= CHECK;
          end
          CHECK: begin
            ack_q[id_q] <= 1'b1;
            rd_data_q   <= d_out;
            rd_id_q     <= id_q;
            ptr_q       <= id_q + 2'd1;
            if (d_out != d_in_q) begin
              mismatch_q <= 1'b1;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
            state_q <= IDLE;
          end
          default: state_q <= WAIT_RDY;
        endcase
      end
    end
  end

  assign ack      = ack_q;
  assign d_in     = d_in_q;
  assign d_en     = d_en_q;
  assign rd_data  = rd_data_q;
  assign rd_id    = rd_id_q;
  assign mismatch = mismatch_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_ff_en_arbiter.sv
module tb_ff_en_arbiter;
  localparam int unsigned WIDTH = 10;
  localparam int unsigned NREQ  = 4;

  logic                  clock = 1'b0;
  logic                  rst   = 1'b1;
  logic                  rdy   = 1'b0;
  logic [NREQ-1:0]       req   = '0;
  logic [NREQ*WIDTH-1:0] wdata = '0;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      d_in;
  logic                  d_en;
  logic [WIDTH-1:0]      d_out;
  logic [WIDTH-1:0]      rd_data;
  logic [1:0]            rd_id;
  logic                  mismatch;
  logic [7:0]            err_cnt;

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  // ff_en model; can be forced to return a wrong value on write.
  logic [WIDTH-1:0] mdl_q = '0;
  logic             force_en  = 1'b0;
  logic [WIDTH-1:0] force_val = '0;
  always @(posedge clock) if (d_en) mdl_q <= force_en ? force_val : d_in;
  assign d_out = mdl_q;

  always #5 clock = ~clock;

  ff_en_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clock(clock), .rst(rst), .rdy(rdy), .req(req), .wdata(wdata),
    .ack(ack), .d_in(d_in), .d_en(d_en), .d_out(d_out),
    .rd_data(rd_data), .rd_id(rd_id), .mismatch(mismatch), .err_cnt(err_cnt)
  );

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b0; req = 4'b0001;
    wdata = '0; wdata[0*WIDTH +: WIDTH] = 10'h0AA;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) rst = 1'b0;
      tick();
      nvec++;
      if (d_en !== 1'b0) begin nmis++; $display("FAIL reset_den cyc%0d: got %b exp 0", i, d_en); end
    end
    nvec++; if (ack !== 4'b0)   begin nmis++; $display("FAIL reset_ack: got %b exp 0000", ack); end
    nvec++; if (d_in !== 10'h0) begin nmis++; $display("FAIL reset_din: got %h exp 000", d_in); end
    nvec++; if (rd_data !== 10'h0) begin nmis++; $display("FAIL reset_rddata: got %h exp 000", rd_data); end
    nvec++; if (rd_id !== 2'd0) begin nmis++; $display("FAIL reset_rdid: got %0d exp 0", rd_id); end
    nvec++; if (mismatch !== 1'b0) begin nmis++; $display("FAIL reset_mismatch: got %b exp 0", mismatch); end
    nvec++; if (err_cnt !== 8'd0) begin nmis++; $display("FAIL reset_errcnt: got %0d exp 0", err_cnt); end
    rdy = 1'b1;
    tick();
    nvec++; if (d_en !== 1'b0) begin nmis++; $display("FAIL rdy_den_early: got %b exp 0", d_en); end
    tick();
    nvec++; if (d_en !== 1'b1) begin nmis++; $display("FAIL rdy_den_pulse: got %b exp 1", d_en); end
    nvec++; if (d_in !== 10'h0AA) begin nmis++; $display("FAIL rdy_din: got %h exp 0aa", d_in); end
    tick(); tick();
    nvec++; if (ack !== 4'b0001) begin nmis++; $display("FAIL rdy_ack: got %b exp 0001", ack); end
    nvec++; if (rd_data !== 10'h0AA) begin nmis++; $display("FAIL rdy_rddata: got %h exp 0aa", rd_data); end
    req = '0;
    tick();
  endtask

  task automatic test_single_write();
    req = 4'b0100;
    wdata = '0; wdata[2*WIDTH +: WIDTH] = 10'h155;
    tick();
    nvec++; if (d_en !== 1'b1) begin nmis++; $display("FAIL single_den: got %b exp 1", d_en); end
    nvec++; if (d_in !== 10'h155) begin nmis++; $display("FAIL single_din: got %h exp 155", d_in); end
    nvec++; if (ack !== 4'b0) begin nmis++; $display("FAIL single_ack_early: got %b exp 0000", ack); end
    tick();
    nvec++; if (d_en !== 1'b0) begin nmis++; $display("FAIL single_den_off: got %b exp 0", d_en); end
    nvec++; if (d_in !== 10'h155) begin nmis++; $display("FAIL single_din_hold: got %h exp 155", d_in); end
    nvec++; if (ack !== 4'b0) begin nmis++; $display("FAIL single_ack_check: got %b exp 0000", ack); end
    tick();
    nvec++; if (ack !== 4'b0100) begin nmis++; $display("FAIL single_ack: got %b exp 0100", ack); end
    nvec++; if (rd_data !== 10'h155) begin nmis++; $display("FAIL single_rddata: got %h exp 155", rd_data); end
    nvec++; if (rd_id !== 2'd2) begin nmis++; $display("FAIL single_rdid: got %0d exp 2", rd_id); end
    nvec++; if (mismatch !== 1'b0) begin nmis++; $display("FAIL single_mismatch: got %b exp 0", mismatch); end
    nvec++; if (d_en !== 1'b0) begin nmis++; $display("FAIL single_den_ack: got %b exp 0", d_en); end
    req = '0;
    tick();
    nvec++; if (ack !== 4'b0) begin nmis++; $display("FAIL single_ack_pulse: got %b exp 0000", ack); end
  endtask

  task automatic test_round_robin();
    logic [WIDTH-1:0] slice [4];
    int last_cyc;
    bit got;
    slice[0] = 10'h3FF; slice[1] = 10'h000; slice[2] = 10'h155; slice[3] = 10'h288;
    rst = 1'b1; rdy = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) wdata[i*WIDTH +: WIDTH] = slice[i];
    req = 4'b1111;
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      got = 1'b0;
      for (int t = 0; t < 6; t++) begin
        tick();
        if (ack !== 4'b0) begin got = 1'b1; break; end
      end
      nvec++;
      if (!got) begin
        nmis++; $display("FAIL rr_timeout k%0d: got no ack exp ack within 6 cycles", k);
      end else begin
        nvec++;
        if (ack !== (4'b0001 << (k % 4))) begin nmis++; $display("FAIL rr_ack k%0d: got %b exp id %0d", k, ack, k % 4); end
        nvec++;
        if (rd_data !== slice[k % 4]) begin nmis++; $display("FAIL rr_rddata k%0d: got %h exp %h", k, rd_data, slice[k % 4]); end
        nvec++;
        if (rd_id !== 2'(k % 4)) begin nmis++; $display("FAIL rr_rdid k%0d: got %0d exp %0d", k, rd_id, k % 4); end
        if (k > 0) begin
          nvec++;
          if (cyc - last_cyc != 3) begin nmis++; $display("FAIL rr_spacing k%0d: got %0d exp 3", k, cyc - last_cyc); end
        end
        last_cyc = cyc;
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_mismatch();
    int nack;
    bit got;
    force_en = 1'b1; force_val = 10'h288;
    req = 4'b0001;
    wdata = '0; wdata[0*WIDTH +: WIDTH] = 10'h3FF;
    got = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (ack !== 4'b0) begin got = 1'b1; break; end
    end
    nvec++;
    if (!got) begin
      nmis++; $display("FAIL mm_timeout: got no ack exp ack within 6 cycles");
    end else begin
      nvec++; if (ack !== 4'b0001) begin nmis++; $display("FAIL mm_ack: got %b exp 0001", ack); end
      nvec++; if (mismatch !== 1'b1) begin nmis++; $display("FAIL mm_pulse: got %b exp 1", mismatch); end
      nvec++; if (err_cnt !== 8'd1) begin nmis++; $display("FAIL mm_errcnt1: got %0d exp 1", err_cnt); end
      nvec++; if (rd_data !== 10'h288) begin nmis++; $display("FAIL mm_rddata: got %h exp 288", rd_data); end
    end
    tick();
    nvec++; if (mismatch !== 1'b0) begin nmis++; $display("FAIL mm_pulse_width: got %b exp 0", mismatch); end
    nvec++; if (d_en !== 1'b1) begin nmis++; $display("FAIL mm_regrant: got %b exp 1", d_en); end
    nack = 1;
    for (int t = 0; t < 1000 && nack < 300; t++) begin
      tick();
      if (ack !== 4'b0) nack++;
    end
    req = '0;
    nvec++; if (nack != 300) begin nmis++; $display("FAIL mm_count_timeout: got %0d acks exp 300", nack); end
    nvec++; if (err_cnt !== 8'd255) begin nmis++; $display("FAIL mm_saturate: got %0d exp 255", err_cnt); end
    tick();
    force_en = 1'b0;
    nvec++; if (err_cnt !== 8'd255) begin nmis++; $display("FAIL mm_saturate_hold: got %0d exp 255", err_cnt); end
  endtask

  task automatic test_rdy_drop();
    req = 4'b0010;
    wdata = '0; wdata[1*WIDTH +: WIDTH] = 10'h1C3;
    tick();
    nvec++; if (d_en !== 1'b1) begin nmis++; $display("FAIL drop_grant: got %b exp 1", d_en); end
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++; if (ack !== 4'b0) begin nmis++; $display("FAIL drop_ack cyc%0d: got %b exp 0000", i, ack); end
      nvec++; if (d_en !== 1'b0) begin nmis++; $display("FAIL drop_den cyc%0d: got %b exp 0", i, d_en); end
    end
    rdy = 1'b1;
    tick();
    nvec++; if (d_en !== 1'b0) begin nmis++; $display("FAIL drop_idle_den: got %b exp 0", d_en); end
    tick();
    nvec++; if (d_en !== 1'b1) begin nmis++; $display("FAIL drop_regrant: got %b exp 1", d_en); end
    nvec++; if (d_in !== 10'h1C3) begin nmis++; $display("FAIL drop_din: got %h exp 1c3", d_in); end
    tick(); tick();
    nvec++; if (ack !== 4'b0010) begin nmis++; $display("FAIL drop_ack_final: got %b exp 0010", ack); end
    nvec++; if (rd_data !== 10'h1C3) begin nmis++; $display("FAIL drop_rddata: got %h exp 1c3", rd_data); end
    nvec++; if (mismatch !== 1'b0) begin nmis++; $display("FAIL drop_mismatch: got %b exp 0", mismatch); end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid_check();
    req = 4'b1000;
    wdata = '0; wdata[3*WIDTH +: WIDTH] = 10'h2AB;
    tick();
    nvec++; if (d_en !== 1'b1) begin nmis++; $display("FAIL rmc_grant: got %b exp 1", d_en); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; req = '0;
    nvec++; if (ack !== 4'b0) begin nmis++; $display("FAIL rmc_ack: got %b exp 0000", ack); end
    nvec++; if (d_in !== 10'h0) begin nmis++; $display("FAIL rmc_din: got %h exp 000", d_in); end
    nvec++; if (d_en !== 1'b0) begin nmis++; $display("FAIL rmc_den: got %b exp 0", d_en); end
    nvec++; if (rd_data !== 10'h0) begin nmis++; $display("FAIL rmc_rddata: got %h exp 000", rd_data); end
    nvec++; if (rd_id !== 2'd0) begin nmis++; $display("FAIL rmc_rdid: got %0d exp 0", rd_id); end
    nvec++; if (mismatch !== 1'b0) begin nmis++; $display("FAIL rmc_mismatch: got %b exp 0", mismatch); end
    nvec++; if (err_cnt !== 8'd0) begin nmis++; $display("FAIL rmc_errcnt: got %0d exp 0", err_cnt); end
    tick();
    nvec++; if (ack !== 4'b0) begin nmis++; $display("FAIL rmc_ack_after: got %b exp 0000", ack); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_mismatch();
    test_rdy_drop();
    test_reset_mid_check();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
